proc_io_bridge: RTL and testbench
=================================

PROC_IO_BRIDGE -- requirements
Module: proc_io_bridge

Interface
REQ-001 Parameter NUBITS, default 32, data word width shared with the processor I/O bus.
REQ-002 Parameter NUIOOU, default 2, number of one-hot output enables driven by the processor-side decoder.
REQ-003 Parameter DEPTH, default 8, input FIFO depth in words; power of two, 2..256.
REQ-004 Parameter ITHRES, default 4, input FIFO level that raises the interrupt; range 1..DEPTH.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 src_data  input  NUBITS  word from the external producer.
REQ-008 src_valid  input  1  producer offers src_data this cycle.
REQ-009 src_ready  output  1  bridge accepts src_data; equals not-full.
REQ-010 io_in  output  NUBITS  word presented to the processor input port.
REQ-011 req_in  input  1  processor consumes io_in this cycle.
REQ-012 io_out  input  NUBITS  processor output word.
REQ-013 out_en  input  NUIOOU  one-hot write strobe per output channel.
REQ-014 dst_data  output  NUIOOU*NUBITS  output channel registers, channel k at bits [k*NUBITS +: NUBITS].
REQ-015 dst_valid  output  NUIOOU  channel k holds an unconsumed word.
REQ-016 dst_ready  input  NUIOOU  consumer takes channel k word when dst_valid[k] is also high.
REQ-017 itr  output  1  interrupt request to the processor.
REQ-018 level  output  $clog2(DEPTH)+1  current input FIFO occupancy.
REQ-019 err  output  2  sticky flags: bit0 underflow, bit1 overflow.

Function
REQ-020 Input FIFO SHALL push on src_valid && src_ready; write pointer wraps modulo DEPTH.
REQ-021 io_in SHALL show the FIFO head combinationally (zero read latency); SHALL be 0 when empty.
REQ-022 req_in while non-empty SHALL pop one word at the clock edge.
REQ-023 req_in while empty SHALL leave pointers unchanged and set err[0].
REQ-024 Simultaneous push and pop SHALL keep level unchanged; when full, push and pop in the same cycle SHALL not occur because src_ready is low.
REQ-025 Simultaneous push and pop on an empty FIFO: push succeeds, pop is an underflow (err[0] set), io_in stays 0 that cycle.
REQ-026 out_en[k] SHALL load io_out into channel k register and set dst_valid[k] at the next edge.
REQ-027 out_en with more than one bit set SHALL load every selected channel with the same io_out word.
REQ-028 dst_valid[k] && dst_ready[k] SHALL clear dst_valid[k] unless out_en[k] reloads it in the same cycle, in which case dst_valid[k] stays 1 with the new data.
REQ-029 out_en[k] while dst_valid[k] is high and dst_ready[k] is low SHALL overwrite the word and set err[1].
REQ-030 err flags SHALL clear only on reset.
REQ-031 Interrupt state machine: IDLE -> ARMED when level < ITHRES; ARMED -> FIRE when level >= ITHRES; FIRE -> WAIT after one cycle; WAIT -> ARMED when level < ITHRES.
REQ-032 itr SHALL be high exactly one cycle, in state FIRE, i.e. a single pulse per upward threshold crossing.

Reset
REQ-033 During rst: FIFO pointers and level 0, src_ready 1, io_in 0, dst_data 0, dst_valid 0, err 0, itr 0, interrupt FSM in IDLE.
REQ-034 Reset asserted mid-transfer SHALL discard FIFO contents and pending output words with no further strobes.

Configuration
REQ-035 Macro PROC_IO_ITR_EN defined: interrupt FSM and itr as REQ-031/032.
REQ-036 Macro PROC_IO_ITR_EN undefined: FSM omitted, itr tied 0, all other behaviour identical.

Verification
REQ-037 Push 0x11,0x22,0x33, then req_in 3 cycles -> io_in reads 0x11,0x22,0x33, level 3->0, err 0.
REQ-038 Push 8 words with DEPTH 8 -> src_ready 0, level 8; 9th src_valid ignored; one req_in -> src_ready 1.
REQ-039 req_in on empty FIFO -> io_in 0, level 0, err[0] 1 until rst.
REQ-040 out_en=2'b01 with io_out 0xDEADBEEF, dst_ready 0, then out_en=2'b01 with 0x5 -> dst_data[31:0] 0x5, dst_valid 2'b01, err[1] 1.
REQ-041 With PROC_IO_ITR_EN, ITHRES 4: push to level 4 -> single itr pulse; pop to 3, push to 4 -> second pulse; hold at 5 -> no further pulse.
REQ-042 rst asserted with level 5 and dst_valid 2'b11 -> all outputs at reset values within the same cycle, no itr.

Source files
------------

// File: rtl/proc_io_bridge.sv
// Processor I/O bridge: producer-fed input FIFO with zero-latency head, one-hot output channel registers.
// Optional threshold interrupt (single pulse per upward level crossing) enabled by defining PROC_IO_ITR_EN.
module proc_io_bridge #(
    parameter int NUBITS = 32,
    parameter int NUIOOU = 2,
    parameter int DEPTH  = 8,
    parameter int ITHRES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUBITS-1:0]          src_data,
    input  logic                       src_valid,
    output logic                       src_ready,
    output logic [NUBITS-1:0]          io_in,
    input  logic                       req_in,
    input  logic [NUBITS-1:0]          io_out,
    input  logic [NUIOOU-1:0]          out_en,
    output logic [NUIOOU*NUBITS-1:0]   dst_data,
    output logic [NUIOOU-1:0]          dst_valid,
    input  logic [NUIOOU-1:0]          dst_ready,
    output logic                       itr,
    output logic [$clog2(DEPTH):0]     level,
    output logic [1:0]                 err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [NUBITS-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     count;
    logic              empty;
    logic              push;
    logic              pop;
    logic              underflow;
    logic              overflow;

    assign empty     = (count == '0);
    assign src_ready = (count != LW'(DEPTH));
    assign push      = src_valid && src_ready;
    assign pop       = req_in && !empty;
    assign underflow = req_in && empty;
    assign overflow  = |(out_en & dst_valid & ~dst_ready);
    assign io_in     = empty ? '0 : mem[rd_ptr];
    assign level     = count;

    // Storage carries no reset; emptiness is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= src_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // A reload on the same edge as a handshake keeps the channel valid with the new word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_data  <= '0;
            dst_valid <= '0;
        end else begin
            for (int k = 0; k < NUIOOU; k++) begin
                if (out_en[k]) begin
                    dst_data[k*NUBITS +: NUBITS] <= io_out;
                end
            end
            dst_valid <= out_en | (dst_valid & ~dst_ready);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= '0;
        end else begin
            err <= err | {overflow, underflow};
        end
    end

`ifdef PROC_IO_ITR_EN
    typedef enum logic [1:0] {
        ITR_IDLE  = 2'd0,
        ITR_ARMED = 2'd1,
        ITR_FIRE  = 2'd2,
        ITR_WAIT  = 2'd3
    } itr_state_t;

    itr_state_t state;
    itr_state_t state_nxt;
    logic       below;

    assign below = (count < LW'(ITHRES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ITR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ITR_IDLE:  if (below)  state_nxt = ITR_ARMED;
            ITR_ARMED: if (!below) state_nxt = ITR_FIRE;
            ITR_FIRE:              state_nxt = ITR_WAIT;
            ITR_WAIT:  if (below)  state_nxt = ITR_ARMED;
            default:               state_nxt = ITR_IDLE;
        endcase
    end

    always_comb begin
        itr = 1'b0;
        if (state == ITR_FIRE) begin
            itr = 1'b1;
        end
    end
`else
    assign itr = 1'b0;
`endif

endmodule

// File: tb/tb_proc_io_bridge.sv
// Bench for proc_io_bridge: directed scenarios then randomized traffic against a queue-based reference model.
module tb_proc_io_bridge;

    localparam int NUBITS = 32;
    localparam int NUIOOU = 2;
    localparam int DEPTH  = 8;
    localparam int ITHRES = 4;
`ifdef PROC_IO_ITR_EN
    localparam bit ITR_EN = 1'b1;
`else
    localparam bit ITR_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUBITS-1:0]        src_data;
    logic                     src_valid;
    logic                     src_ready;
    logic [NUBITS-1:0]        io_in;
    logic                     req_in;
    logic [NUBITS-1:0]        io_out;
    logic [NUIOOU-1:0]        out_en;
    logic [NUIOOU*NUBITS-1:0] dst_data;
    logic [NUIOOU-1:0]        dst_valid;
    logic [NUIOOU-1:0]        dst_ready;
    logic                     itr;
    logic [$clog2(DEPTH):0]   level;
    logic [1:0]               err;

    proc_io_bridge #(.NUBITS(NUBITS), .NUIOOU(NUIOOU), .DEPTH(DEPTH), .ITHRES(ITHRES)) dut (
        .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .io_in(io_in), .req_in(req_in), .io_out(io_out), .out_en(out_en), .dst_data(dst_data),
        .dst_valid(dst_valid), .dst_ready(dst_ready), .itr(itr), .level(level), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int itr_pulses = 0;

    // Reference model state
    logic [NUBITS-1:0] q[$];
    logic [NUBITS-1:0] ch_data [NUIOOU];
    logic              ch_vld  [NUIOOU];
    logic [1:0]        m_err;
    logic              m_itr;
    logic              m_armed;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < NUIOOU; k++) begin
            ch_data[k] = '0;
            ch_vld[k]  = 1'b0;
        end
        m_err   = 2'b00;
        m_itr   = 1'b0;
        m_armed = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [NUIOOU*NUBITS-1:0] exp_data;
        logic [NUIOOU-1:0]        exp_vld;
        for (int k = 0; k < NUIOOU; k++) begin
            exp_data[k*NUBITS +: NUBITS] = ch_data[k];
            exp_vld[k] = ch_vld[k];
        end
        check({tag, ".level"}, 64'(level), 64'(q.size()));
        check({tag, ".io_in"}, 64'(io_in), (q.size() > 0) ? 64'(q[0]) : 64'd0);
        check({tag, ".src_ready"}, 64'(src_ready), 64'(q.size() < DEPTH));
        check({tag, ".dst_data"}, 64'(dst_data), 64'(exp_data));
        check({tag, ".dst_valid"}, 64'(dst_valid), 64'(exp_vld));
        check({tag, ".err"}, 64'(err), 64'(m_err));
        check({tag, ".itr"}, 64'(itr), 64'(ITR_EN ? m_itr : 1'b0));
    endtask

    // Apply inputs for one cycle, advance the model across the edge, then compare.
    task automatic step(input string tag, input logic sv, input logic [NUBITS-1:0] sd, input logic rq,
                        input logic [NUIOOU-1:0] oe, input logic [NUBITS-1:0] od,
                        input logic [NUIOOU-1:0] dr);
        int lvl;
        bit do_push;
        src_valid = sv; src_data = sd; req_in = rq;
        out_en = oe; io_out = od; dst_ready = dr;
        lvl = q.size();
        do_push = sv && (lvl < DEPTH);
        if (rq) begin
            if (lvl > 0) void'(q.pop_front());
            else m_err[0] = 1'b1;
        end
        if (do_push) q.push_back(sd);
        for (int k = 0; k < NUIOOU; k++) begin
            if (oe[k]) begin
                if (ch_vld[k] && !dr[k]) m_err[1] = 1'b1;
                ch_data[k] = od;
                ch_vld[k]  = 1'b1;
            end else if (dr[k]) begin
                ch_vld[k] = 1'b0;
            end
        end
        // Interrupt: one pulse once the level reaches the threshold after having been below it.
        if (m_itr) begin
            m_itr = 1'b0;
        end else if (m_armed && lvl >= ITHRES) begin
            m_itr   = 1'b1;
            m_armed = 1'b0;
        end else if (lvl < ITHRES) begin
            m_armed = 1'b1;
        end
        @(posedge clk);
        #1;
        if (itr) itr_pulses++;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        int p0;
        rst = 1'b1;
        src_valid = 1'b0; src_data = '0; req_in = 1'b0;
        out_en = '0; io_out = '0; dst_ready = '0;
        model_reset();
        #12;
        check_all("reset_hold");
        @(posedge clk); #1;
        rst = 1'b0;

        // In-order read-out with zero read latency
        step("push11", 1'b1, 32'h11, 1'b0, '0, '0, '0);
        step("push22", 1'b1, 32'h22, 1'b0, '0, '0, '0);
        step("push33", 1'b1, 32'h33, 1'b0, '0, '0, '0);
        check("head11", 64'(io_in), 64'h11);
        for (int i = 0; i < 3; i++) step("pop3", 1'b0, '0, 1'b1, '0, '0, '0);
        check("drained_err", 64'(err), 64'd0);

        // Fill to full, ignored extra push, one pop restores ready
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 32'hA0 + 32'(i), 1'b0, '0, '0, '0);
        check("full_ready", 64'(src_ready), 64'd0);
        step("push9", 1'b1, 32'hBAD, 1'b0, '0, '0, '0);
        step("pop_full", 1'b0, '0, 1'b1, '0, '0, '0);
        check("ready_after_pop", 64'(src_ready), 64'd1);
        step("pushpop", 1'b1, 32'hC1, 1'b1, '0, '0, '0);
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, '0, 1'b1, '0, '0, '0);

        // Underflow is sticky; push plus pop on empty counts as underflow
        step("underflow", 1'b0, '0, 1'b1, '0, '0, '0);
        step("empty_pushpop", 1'b1, 32'h77, 1'b1, '0, '0, '0);
        idle("sticky0", 2);
        step("pop77", 1'b0, '0, 1'b1, '0, '0, '0);

        // Output channel overwrite and multi-select
        step("out_dead", 1'b0, '0, 1'b0, 2'b01, 32'hDEADBEEF, 2'b00);
        step("out_5", 1'b0, '0, 1'b0, 2'b01, 32'h5, 2'b00);
        check("ch0_word", 64'(dst_data[31:0]), 64'h5);
        step("out_both", 1'b0, '0, 1'b0, 2'b11, 32'h1234, 2'b11);
        step("reload_hs", 1'b0, '0, 1'b0, 2'b10, 32'h9, 2'b11);
        step("consume", 1'b0, '0, 1'b0, 2'b00, '0, 2'b11);

        // Threshold interrupt: one pulse per upward crossing
        p0 = itr_pulses;
        for (int i = 0; i < 4; i++) step("up4", 1'b1, 32'(i), 1'b0, '0, '0, '0);
        idle("hold4", 3);
        step("down3", 1'b0, '0, 1'b1, '0, '0, '0);
        idle("hold3", 1);
        step("up4b", 1'b1, 32'h44, 1'b0, '0, '0, '0);
        idle("hold4b", 2);
        step("up5", 1'b1, 32'h55, 1'b0, '0, '0, '0);
        idle("hold5", 4);
        check("itr_pulses", 64'(itr_pulses - p0), ITR_EN ? 64'd2 : 64'd0);

        // Asynchronous reset with level 5 and both channels pending
        step("out_pend", 1'b0, '0, 1'b0, 2'b11, 32'hCAFE, 2'b00);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        src_valid = 1'b0; req_in = 1'b0; out_en = '0; dst_ready = '0;
        @(posedge clk); @(posedge clk); #1;
        check_all("rst_held");
        rst = 1'b0;

        // Randomized traffic: fill-biased, then drain-biased, then balanced
        for (int i = 0; i < 450; i++) begin
            int pv, pr;
            pv = (i < 150) ? 80 : (i < 300) ? 30 : 55;
            pr = (i < 150) ? 25 : (i < 300) ? 75 : 50;
            step("rand", ($urandom_range(99) < pv), $urandom, ($urandom_range(99) < pr),
                 NUIOOU'($urandom_range(3)), $urandom, NUIOOU'($urandom_range(3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
